// File: rtl/johnson_pkg.sv
// johnson_pkg: shared types and helpers for the Johnson code transmitter/receiver pair
//   state_t       HUNT/LOCKED flywheel state
//   johnson_next  one step of the transmitter ring (shift right, MSB takes ~LSB)
//   NUM_STATES    length of the Johnson sequence (2*JC_WIDTH)
package johnson_pkg;
    localparam int JC_WIDTH = 8;
    localparam int NUM_STATES = 2 * JC_WIDTH;
    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;
    function automatic logic [JC_WIDTH-1:0] johnson_next(input logic [JC_WIDTH-1:0] code);
        return {~code[0], code[JC_WIDTH-1:1]};
    endfunction
endpackage

// File: rtl/johnson_code_check.sv
// johnson_code_check: combinational Johnson word legality check and index decode
//   code   in  WIDTH  Johnson-coded word
//   legal  out 1      code is one of the 2*WIDTH legal words
//   idx    out IDX_W  decoded sequence index, 0 for illegal words
module johnson_code_check #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] code,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [IDX_W:0] W_L = (IDX_W+1)'(WIDTH);
    localparam logic [IDX_W:0] NS = (IDX_W+1)'(2 * WIDTH);
    logic [IDX_W:0] p, idx_full;
    // LSB=0 words are a block of ones hanging from the MSB (first half of the
    // sequence); LSB=1 words are a block of ones resting on the LSB (second half)
    always_comb begin
        p = '0;
        for (int i = 0; i < WIDTH; i++) p = p + (IDX_W+1)'(code[i]);
        legal = code[0] ? (code == (ONES >> (W_L - p))) : (code == ~(ONES >> p));
        idx_full = code[0] ? NS - p : p;
        idx = legal ? idx_full[IDX_W-1:0] : '0;
    end
endmodule

// File: rtl/johnson_decoder.sv
// johnson_decoder: Johnson code receiver with legality check, index decode and lock flywheel
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   in_valid    sample strobe for in_code
//   in_code     Johnson-coded word
//   err_clr     synchronous clear of err_count
//   idx_out     decoded index of the last sample
//   idx_valid   one-cycle pulse when idx_out/code_legal update
//   code_legal  last sample was a legal code
//   seq_err     one-cycle pulse on a sequence error while LOCKED
//   locked      flywheel is LOCKED
//   err_count   saturating count of seq_err pulses
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int WIDTH = JC_WIDTH,
    parameter int IDX_W = 4,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_code,
    input  logic             err_clr,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    output logic             code_legal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(2 * WIDTH - 1);
    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);
    logic legal, good, ref_ok, ref_ok_n, seq_err_n;
    logic [IDX_W-1:0] idx, ref_idx, ref_n, succ;
    logic [3:0] run, run_n, miss, miss_n;
    logic [ERR_W-1:0] err_n;
    state_t state, state_n;
    johnson_code_check #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_check (
        .code (in_code),
        .legal(legal),
        .idx  (idx)
    );
    always_comb begin
        state_n = state;
        run_n = run;
        miss_n = miss;
        ref_n = ref_idx;
        ref_ok_n = ref_ok;
        seq_err_n = 1'b0;
        succ = (ref_idx == LAST) ? '0 : ref_idx + 1'b1;
        good = legal && (idx == succ);
        if (in_valid) begin
            if (state == HUNT) begin
                if (legal) begin
                    run_n = (good && ref_ok) ? run + 1'b1 : '0;
                    ref_n = idx;
                    ref_ok_n = 1'b1;
                    if (run_n == LOCK_N) begin
                        state_n = LOCKED;
                        run_n = '0;
                        miss_n = '0;
                    end
                end else begin
                    run_n = '0;
                    ref_ok_n = 1'b0;
                end
            end else begin
                // flywheel: the reference keeps turning even across bad samples
                ref_n = succ;
                seq_err_n = !good;
                miss_n = good ? '0 : miss + 1'b1;
                if (miss_n == LOSS_N) begin
                    state_n = HUNT;
                    run_n = '0;
                    miss_n = '0;
                    ref_ok_n = 1'b0;
                end
            end
        end
        // a clear coinciding with an error leaves that error counted
        err_n = err_clr ? ERR_W'(seq_err_n) :
                (seq_err_n && !(&err_count)) ? err_count + 1'b1 : err_count;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
            run <= '0;
            miss <= '0;
            ref_idx <= '0;
            ref_ok <= 1'b0;
            idx_out <= '0;
            idx_valid <= 1'b0;
            code_legal <= 1'b0;
            seq_err <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_n;
            run <= run_n;
            miss <= miss_n;
            ref_idx <= ref_n;
            ref_ok <= ref_ok_n;
            idx_out <= in_valid ? idx : idx_out;
            code_legal <= in_valid ? legal : code_legal;
            idx_valid <= in_valid;
            seq_err <= seq_err_n;
            err_count <= err_n;
        end
    end
    assign locked = (state == LOCKED);
endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: directed self-checking bench for johnson_decoder
module tb_johnson_decoder;
    import johnson_pkg::*;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, err_clr = 1'b0;
    logic [7:0] in_code = '0;
    logic [3:0] idx_out;
    logic idx_valid, code_legal, seq_err, locked;
    logic [7:0] err_count;
    int checks = 0, errors = 0;

    johnson_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .err_clr(err_clr),
        .idx_out(idx_out), .idx_valid(idx_valid), .code_legal(code_legal),
        .seq_err(seq_err), .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] code_of(input int k);
        logic [7:0] ones = 8'hFF;
        int m = k % 16;
        return (m <= 8) ? ~(ones >> m) : (ones >> (m - 8));
    endfunction

    task automatic drive(input logic v, input logic [7:0] c);
        @(negedge clk);
        in_valid = v;
        in_code = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (idx_out !== 4'd0) begin errors++; $display("FAIL reset idx_out got %0d want 0", idx_out); end
        checks++; if (idx_valid !== 1'b0 || code_legal !== 1'b0 || seq_err !== 1'b0) begin errors++; $display("FAIL reset flags got %b%b%b want 000", idx_valid, code_legal, seq_err); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset locked got %b want 0", locked); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset err_count got %0d want 0", err_count); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequence();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (johnson_next(code_of(k)) !== code_of(k + 1)) begin errors++; $display("FAIL johnson_next k=%0d got %h want %h", k, johnson_next(code_of(k)), code_of(k + 1)); end
        end
        for (int k = 0; k <= 16; k++) begin
            drive(1'b1, code_of(k));
            checks++;
            if (idx_out !== 4'(k % 16) || idx_valid !== 1'b1 || code_legal !== 1'b1) begin errors++; $display("FAIL seq k=%0d idx got %0d/%b/%b want %0d/1/1", k, idx_out, idx_valid, code_legal, k % 16); end
            checks++;
            if (locked !== (k >= 4) || seq_err !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL seq k=%0d lock/err got %b/%b/%0d want %b/0/0", k, locked, seq_err, err_count, k >= 4); end
        end
    endtask

    task automatic test_illegal();
        for (int k = 1; k <= 5; k++) drive(1'b1, code_of(k));
        drive(1'b1, 8'hA5);
        checks++; if (seq_err !== 1'b1 || code_legal !== 1'b0 || idx_out !== 4'd0) begin errors++; $display("FAIL illegal got seq_err=%b legal=%b idx=%0d want 1 0 0", seq_err, code_legal, idx_out); end
        checks++; if (err_count !== 8'd1 || locked !== 1'b1) begin errors++; $display("FAIL illegal got err_count=%0d locked=%b want 1 1", err_count, locked); end
        drive(1'b1, 8'hFE);
        checks++; if (seq_err !== 1'b0 || idx_out !== 4'd7 || locked !== 1'b1) begin errors++; $display("FAIL resume got seq_err=%b idx=%0d locked=%b want 0 7 1", seq_err, idx_out, locked); end
        drive(1'b1, code_of(8));
    endtask

    task automatic test_loss();
        err_clr = 1'b1;
        drive(1'b0, 8'h00);
        err_clr = 1'b0;
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL err_clr got %0d want 0", err_count); end
        drive(1'b1, code_of(3));
        checks++; if (seq_err !== 1'b1 || locked !== 1'b1 || idx_out !== 4'd3) begin errors++; $display("FAIL loss1 got seq_err=%b locked=%b idx=%0d want 1 1 3", seq_err, locked, idx_out); end
        drive(1'b1, code_of(3));
        checks++; if (seq_err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd2) begin errors++; $display("FAIL loss2 got seq_err=%b locked=%b err=%0d want 1 0 2", seq_err, locked, err_count); end
        for (int k = 5; k <= 9; k++) begin
            drive(1'b1, code_of(k));
            checks++;
            if (locked !== (k == 9) || seq_err !== 1'b0) begin errors++; $display("FAIL relock k=%0d got locked=%b seq_err=%b want %b 0", k, locked, seq_err, k == 9); end
        end
    endtask

    task automatic test_gap();
        for (int k = 10; k <= 12; k++) drive(1'b1, code_of(k));
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 8'h55);
            checks++;
            if (idx_valid !== 1'b0 || seq_err !== 1'b0 || locked !== 1'b1 || idx_out !== 4'd12) begin errors++; $display("FAIL gap i=%0d got v=%b e=%b l=%b idx=%0d want 0 0 1 12", i, idx_valid, seq_err, locked, idx_out); end
        end
        drive(1'b1, code_of(13));
        checks++; if (idx_valid !== 1'b1 || idx_out !== 4'd13 || seq_err !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL gap resume got v=%b idx=%0d e=%b l=%b want 1 13 0 1", idx_valid, idx_out, seq_err, locked); end
    endtask

    task automatic test_saturate();
        int e = 14;
        err_clr = 1'b1;
        drive(1'b0, 8'h00);
        err_clr = 1'b0;
        for (int i = 0; i < 255; i++) begin
            drive(1'b1, 8'hA5);
            drive(1'b1, code_of(e + 1));
            e += 2;
        end
        checks++; if (err_count !== 8'd255 || locked !== 1'b1) begin errors++; $display("FAIL sat255 got err=%0d locked=%b want 255 1", err_count, locked); end
        drive(1'b1, 8'hA5);
        checks++; if (err_count !== 8'd255 || seq_err !== 1'b1) begin errors++; $display("FAIL saturate got err=%0d seq_err=%b want 255 1", err_count, seq_err); end
        drive(1'b1, code_of(e + 1));
        e += 2;
        err_clr = 1'b1;
        drive(1'b1, 8'hA5);
        err_clr = 1'b0;
        checks++; if (err_count !== 8'd1 || seq_err !== 1'b1) begin errors++; $display("FAIL clr+err got err=%0d seq_err=%b want 1 1", err_count, seq_err); end
        drive(1'b1, code_of(e + 1));
        checks++; if (locked !== 1'b1 || err_count !== 8'd1) begin errors++; $display("FAIL post clr got locked=%b err=%0d want 1 1", locked, err_count); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_code = 8'h00;
        #2 rst = 1'b1;
        #1;
        checks++; if (locked !== 1'b0 || err_count !== 8'd0 || idx_out !== 4'd0 || idx_valid !== 1'b0 || code_legal !== 1'b0 || seq_err !== 1'b0) begin errors++; $display("FAIL async rst got l=%b err=%0d idx=%0d v=%b c=%b e=%b want all 0", locked, err_count, idx_out, idx_valid, code_legal, seq_err); end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            drive(1'b1, code_of(k));
            checks++;
            if (locked !== (k == 4) || idx_out !== 4'(k)) begin errors++; $display("FAIL post rst k=%0d got locked=%b idx=%0d want %b %0d", k, locked, idx_out, k == 4, k); end
        end
        drive(1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_illegal();
        test_loss();
        test_gap();
        test_saturate();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
